// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_8bit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor (in1 - in2, LSB first) behind valid/ready operand and result ports,
// with unsigned borrow, signed overflow and zero flags.
module serial_subtractor_8bit
  import serial_subtractor_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           next_state;
  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next_c;
  logic             a_msb;
  logic             b_msb;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;
  logic             d_bit_c;
  logic             bout_bit_c;

  full_subtractor_1bit u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .d    (d_bit_c),
    .bout (bout_bit_c)
  );

  assign res_next_c = {d_bit_c, res_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and control strobes
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept_c   = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c     = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath, handshake flags and result/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
      out        <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      in_ready  <= (next_state == ST_IDLE);
      out_valid <= (next_state == ST_DONE);
      if (accept_c) begin
        a_sr     <= in1;
        b_sr     <= in2;
        res_sr   <= '0;
        a_msb    <= in1[WIDTH-1];
        b_msb    <= in2[WIDTH-1];
        borrow_q <= 1'b0;
        cnt      <= '0;
      end else if (state == ST_SHIFT) begin
        res_sr   <= res_next_c;
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        borrow_q <= bout_bit_c;
        cnt      <= cnt + CNT_W'(1);
        if (last_c) begin
          out        <= res_next_c;
          borrow_out <= bout_bit_c;
          overflow   <= (a_msb != b_msb) && (d_bit_c != a_msb);
          zero       <= ~|res_next_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: vector table, sweep, hold and reset-abort sequences.
module tb_serial_subtractor_8bit;

  typedef struct packed {
    logic [7:0] out;
    logic       borrow;
    logic       ovf;
    logic       zero;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       borrow_out;
  logic       overflow;
  logic       zero;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  res_t sb[$];

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int   sd;
    r.out    = a - b;
    r.borrow = (a < b);
    sd       = int'($signed(a)) - int'($signed(b));
    r.ovf    = (sd > 127) || (sd < -128);
    r.zero   = (r.out == 8'h00);
    return r;
  endfunction

  // Scoreboard: compare every delivered result against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(1), 32'(0));
      end else begin
        res_t e;
        res_t a;
        e = sb.pop_front();
        a = '{out: out, borrow: borrow_out, ovf: overflow, zero: zero};
        check("result", 32'(a), 32'(e));
      end
    end
  end

  task automatic apply_op(input logic [7:0] a, input logic [7:0] b, input res_t exp,
                          input bit push, output int acc_cyc, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_wait", 32'(in_ready), 32'(1));
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("op_timeout", 32'(out_valid), 32'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   acc;
    int   prev;
    int   lat;
    int   seen;

    vecs[0] = '{8'd5,  8'd3,  '{8'h02, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{8'd3,  8'd5,  '{8'hFE, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{8'h80, 8'h01, '{8'h7F, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{8'h7F, 8'hFF, '{8'h80, 1'b1, 1'b1, 1'b0}};
    vecs[4] = '{8'h00, 8'h00, '{8'h00, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{8'hFF, 8'h01, '{8'hFE, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{8'h00, 8'h01, '{8'hFF, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{8'h80, 8'h80, '{8'h00, 1'b0, 1'b0, 1'b1}};
    vecs[8] = '{8'h7F, 8'h80, '{8'hFF, 1'b1, 1'b1, 1'b0}};
    vecs[9] = '{8'h01, 8'h80, '{8'h81, 1'b1, 1'b1, 1'b0}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = 8'h00;
    in2       = 8'h00;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out", 32'(out), 32'(0));
    check("rst_flags", 32'({borrow_out, overflow, zero}), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready), 32'(1));

    // Vector table: result, latency, single-cycle out_valid
    for (int i = 0; i < 10; i++) begin
      apply_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, acc, lat);
      check("latency", 32'(lat), 32'(8));
      @(posedge clk); #1;
      check("out_valid_pulse", 32'(out_valid), 32'(0));
    end

    // Equal-operand sweep, back to back
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      apply_op(v, v, model(v, v), 1'b1, acc, lat);
      if (i > 0) check("throughput", 32'(acc - prev), 32'(10));
      prev = acc;
    end
    @(posedge clk); #1;

    // Back-pressure in DONE while new operands are offered
    out_ready = 1'b0;
    apply_op(8'h10, 8'h01, model(8'h10, 8'h01), 1'b1, acc, lat);
    in1      = 8'h01;
    in2      = 8'h80;
    in_valid = 1'b1;
    sb.push_back(res_t'{8'h81, 1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 5; k++) begin
      check("hold_out_valid", 32'(out_valid), 32'(1));
      check("hold_out", 32'(out), 32'(8'h0F));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(out_valid), 32'(0));
    check("release_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_in_ready", 32'(in_ready), 32'(0));
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held_op_latency", 32'(lat), 32'(8));
    @(posedge clk); #1;

    // Reset after 4 shift bits aborts the operation
    apply_op_abort();
    check("abort_in_ready_low", 32'(in_ready), 32'(0));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_out", 32'(out), 32'(0));
    check("abort_flags", 32'({borrow_out, overflow, zero}), 32'(0));
    @(posedge clk); #1;
    check("abort_in_ready", 32'(in_ready), 32'(1));
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'(0));

    apply_op(8'h07, 8'h07, res_t'{8'h00, 1'b0, 1'b0, 1'b1}, 1'b1, acc, lat);
    check("post_reset_latency", 32'(lat), 32'(8));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic apply_op_abort();
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    in1      = 8'hF0;
    in2      = 8'h0F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

endmodule

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial subtractor computing `in1 - in2` one bit per clock, LSB first, through a single 1-bit full subtractor and a borrow flip-flop. It is the inverse-direction companion to the 8-bit ripple-carry adder. It trades area for latency and sits behind a valid/ready operand port and a valid/ready result port. Flags report unsigned borrow, signed overflow and zero, so the block can serve as a compare unit.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be 2 or greater.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: operands `in1`/`in2` are valid.
- `in_ready` output 1: block accepts operands; high only in IDLE.
- `in1` input WIDTH: minuend.
- `in2` input WIDTH: subtrahend.
- `out_valid` output 1: result and flags are valid; high only in DONE.
- `out_ready` input 1: consumer takes the result.
- `out` output WIDTH: `in1 - in2` modulo 2^WIDTH.
- `borrow_out` output 1: 1 when `in1 < in2` (unsigned).
- `overflow` output 1: two's-complement signed overflow of the subtraction.
- `zero` output 1: `out == 0`.

## Operation
- State machine states:
  - IDLE:
    - `in_ready=1`.
    - On `in_valid & in_ready`, capture `in1`/`in2` into shift registers, clear the borrow flip-flop, latch the operand MSBs, clear the bit counter, then go to SHIFT.
  - SHIFT:
    - Each cycle, compute `d = a0 ^ b0 ^ bw` and `bw' = (~a0 & b0) | (~(a0 ^ b0) & bw)` from the operand LSBs and the borrow register.
    - Shift `d` into the result register MSB and shift both operands right.
    - Increment the counter.
    - After WIDTH bit-cycles, go to DONE.
  - DONE:
    - `out_valid=1`; `out` and flags are stable.
    - On `out_ready`, return to IDLE.
- Flags, registered on entry to DONE:
  - `borrow_out` = final borrow.
  - `overflow` = `(a_msb != b_msb) & (out_msb != a_msb)`.
  - `zero` = `~|out`.
- `in_valid` in SHIFT or DONE is ignored; no operands are captured.
- The counter is `$clog2(WIDTH)+1` bits wide and wraps only through reset or a return to IDLE.

## Timing
- Reset (`rst_n=0` at an edge), taking effect from the next cycle:
  - state is IDLE;
  - `out`, `borrow_out`, `overflow`, `zero` and `out_valid` are 0;
  - shift registers, counter and borrow are 0.
- `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Reset mid-SHIFT or in DONE aborts the operation; the partial result is discarded and never presented.
- Latency: acceptance at edge E puts `out_valid` high in the cycle after edge E+WIDTH (WIDTH = 8 gives 8 cycles).
- Throughput: one operation per WIDTH+2 cycles minimum (IDLE, WIDTH shifts, DONE with `out_ready=1`).
- `out_valid`, `out` and flags hold unchanged while `out_ready=0`, indefinitely.
- If `out_ready=1` on the first DONE cycle, `out_valid` is high for exactly one cycle.
- `in_ready` drops the cycle after acceptance; the next acceptance occurs no earlier than the cycle after DONE exits.
- All outputs are registered or decoded directly from state; there are no combinational input-to-output paths.

## Structure
- Shared package/include holds:
  - state encodings (`ST_IDLE`, `ST_SHIFT`, `ST_DONE`);
  - default `WIDTH`.
- One sub-module: `full_subtractor_1bit` (inputs `a`, `b`, `bin`; outputs `d`, `bout`; combinational), instantiated once in the datapath.
- Top level contains the FSM, counter, two operand shift registers, result shift register and flag registers.

## Test plan
- `in1=8'd5`, `in2=8'd3` → `out=8'h02`, `borrow_out=0`, `overflow=0`, `zero=0`; `out_valid` rises exactly 8 cycles after acceptance.
- `in1=8'd3`, `in2=8'd5` → `out=8'hFE`, `borrow_out=1`, `overflow=0`, `zero=0`.
- `in1=8'h80`, `in2=8'h01` → `out=8'h7F`, `overflow=1`, `borrow_out=0`; separately, `8'h7F - 8'hFF` → `out=8'h80`, `overflow=1`, `borrow_out=1`.
- `in1=in2=i` for i = 0..255 (sweep, `out_ready=1`) → every result `out=0`, `zero=1`, `borrow_out=0`; one op completes every 10 cycles.
- `out_ready=0` for 5 cycles in DONE while `in_valid=1` with new operands → `out_valid` and `out` hold, `in_ready=0`, new operands not captured; raise `out_ready` → IDLE next cycle, then the new operands are accepted.
- `rst_n=0` for one edge after 4 SHIFT bits of `8'hF0 - 8'h0F` → next cycle IDLE, all outputs 0, `in_ready=1` after release, and no `out_valid` pulse for the aborted operation.
